// File: rtl/hacd_comp_rdfifo_if.sv
// Bus bundle for the HACD compressor page-staging read buffer: AXI read-data capture side plus the compressor read port.
// The optional zero_line_cnt signal exists only when HACD_RDFIFO_ZERO_CNT_EN is defined.
interface hacd_comp_rdfifo_if #(
  parameter int FIFO_PTR_WIDTH       = 6,
  parameter int HACD_AXI4_DATA_WIDTH = 512
);
  logic                            axi_rvalid;
  logic                            axi_rready;
  logic [HACD_AXI4_DATA_WIDTH-1:0] axi_rdata;
  logic [1:0]                      axi_rresp;
  logic                            page_clr;
  logic                            page_full;
  logic                            rdfifo_empty;
  logic                            ld_rdfifo_rdptr;
  logic [FIFO_PTR_WIDTH-1:0]       rdfifo_rdptr;
  logic                            rd_req;
  logic [HACD_AXI4_DATA_WIDTH-1:0] rd_data;
  logic [1:0]                      rd_rresp;
  logic                            rd_valid;
`ifdef HACD_RDFIFO_ZERO_CNT_EN
  logic [FIFO_PTR_WIDTH:0]         zero_line_cnt;

  modport slave (
    input  axi_rvalid, axi_rdata, axi_rresp, page_clr, ld_rdfifo_rdptr, rdfifo_rdptr, rd_req,
    output axi_rready, page_full, rdfifo_empty, rd_data, rd_rresp, rd_valid, zero_line_cnt
  );

  modport master (
    output axi_rvalid, axi_rdata, axi_rresp, page_clr, ld_rdfifo_rdptr, rdfifo_rdptr, rd_req,
    input  axi_rready, page_full, rdfifo_empty, rd_data, rd_rresp, rd_valid, zero_line_cnt
  );
`else
  modport slave (
    input  axi_rvalid, axi_rdata, axi_rresp, page_clr, ld_rdfifo_rdptr, rdfifo_rdptr, rd_req,
    output axi_rready, page_full, rdfifo_empty, rd_data, rd_rresp, rd_valid
  );

  modport master (
    output axi_rvalid, axi_rdata, axi_rresp, page_clr, ld_rdfifo_rdptr, rdfifo_rdptr, rd_req,
    input  axi_rready, page_full, rdfifo_empty, rd_data, rd_rresp, rd_valid
  );
`endif
endinterface

// File: rtl/hacd_comp_rdfifo.sv
// Page-staging read buffer feeding the HACD compressor: captures one page of AXI beats and serves a re-readable,
// pointer-loadable read port. Optional zero-line counter enabled by defining HACD_RDFIFO_ZERO_CNT_EN.
module hacd_comp_rdfifo #(
  parameter int FIFO_PTR_WIDTH       = 6,
  parameter int HACD_AXI4_DATA_WIDTH = 512
) (
  input logic               clk_i,
  input logic               rst_ni,
  hacd_comp_rdfifo_if.slave bus
);
  localparam int DEPTH = 1 << FIFO_PTR_WIDTH;
  localparam int CW    = FIFO_PTR_WIDTH + 1;

  logic [HACD_AXI4_DATA_WIDTH-1:0] mem_data [DEPTH];
  logic [1:0]                      mem_resp [DEPTH];

  logic [CW-1:0]                   wr_cnt_q, wr_cnt_d;
  logic [CW-1:0]                   rd_idx_q, rd_idx_d;
  logic [CW-1:0]                   rd_base;
  logic [HACD_AXI4_DATA_WIDTH-1:0] rd_data_q, rd_data_d;
  logic [1:0]                      rd_rresp_q, rd_rresp_d;
  logic                            rd_valid_q, rd_valid_d;
  logic                            page_full;
  logic                            axi_rready;
  logic                            wr_en;
  logic                            rd_fire;

  assign page_full  = (wr_cnt_q == CW'(DEPTH));
  assign axi_rready = !page_full && !bus.page_clr;
  assign wr_en      = bus.axi_rvalid && axi_rready;

  // A same-cycle pointer load redirects the read, so emptiness is judged against the loaded index.
  assign rd_base = bus.ld_rdfifo_rdptr ? {1'b0, bus.rdfifo_rdptr} : rd_idx_q;
  assign rd_fire = bus.rd_req && (rd_base < wr_cnt_q) && !bus.page_clr;

  assign bus.axi_rready   = axi_rready;
  assign bus.page_full    = page_full;
  assign bus.rdfifo_empty = (rd_idx_q >= wr_cnt_q);
  assign bus.rd_data      = rd_data_q;
  assign bus.rd_rresp     = rd_rresp_q;
  assign bus.rd_valid     = rd_valid_q;

  always_comb begin
    wr_cnt_d   = wr_cnt_q;
    rd_idx_d   = rd_base;
    rd_data_d  = rd_data_q;
    rd_rresp_d = rd_rresp_q;
    rd_valid_d = 1'b0;
    if (bus.page_clr) begin
      wr_cnt_d = '0;
      rd_idx_d = '0;
    end else begin
      if (wr_en) begin
        wr_cnt_d = wr_cnt_q + 1'b1;
      end
      if (rd_fire) begin
        rd_idx_d   = rd_base + 1'b1;
        rd_data_d  = mem_data[rd_base[FIFO_PTR_WIDTH-1:0]];
        rd_rresp_d = mem_resp[rd_base[FIFO_PTR_WIDTH-1:0]];
        rd_valid_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_cnt_q   <= '0;
      rd_idx_q   <= '0;
      rd_data_q  <= '0;
      rd_rresp_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      wr_cnt_q   <= wr_cnt_d;
      rd_idx_q   <= rd_idx_d;
      rd_data_q  <= rd_data_d;
      rd_rresp_q <= rd_rresp_d;
      rd_valid_q <= rd_valid_d;
    end
  end

  // Storage is not reset; wr_cnt_q alone decides which entries are meaningful.
  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem_data[wr_cnt_q[FIFO_PTR_WIDTH-1:0]] <= bus.axi_rdata;
      mem_resp[wr_cnt_q[FIFO_PTR_WIDTH-1:0]] <= bus.axi_rresp;
    end
  end

`ifdef HACD_RDFIFO_ZERO_CNT_EN
  logic [CW-1:0] zero_cnt_q, zero_cnt_d;

  always_comb begin
    zero_cnt_d = zero_cnt_q;
    if (bus.page_clr) begin
      zero_cnt_d = '0;
    end else if (wr_en && (bus.axi_rdata == '0) && (bus.axi_rresp == 2'b00)) begin
      zero_cnt_d = zero_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      zero_cnt_q <= '0;
    end else begin
      zero_cnt_q <= zero_cnt_d;
    end
  end

  assign bus.zero_line_cnt = zero_cnt_q;
`endif

endmodule

// File: tb/tb_hacd_comp_rdfifo.sv
// Directed self-checking bench for hacd_comp_rdfifo using immediate assertions.
// Zero-line counter checks are included when HACD_RDFIFO_ZERO_CNT_EN is defined.
module tb_hacd_comp_rdfifo;
  localparam int PW = 6;
  localparam int DW = 512;

  logic clk;
  logic rst_n;
  int   errors = 0;
  int   checks = 0;

  hacd_comp_rdfifo_if #(.FIFO_PTR_WIDTH(PW), .HACD_AXI4_DATA_WIDTH(DW)) bus ();

  hacd_comp_rdfifo #(.FIFO_PTR_WIDTH(PW), .HACD_AXI4_DATA_WIDTH(DW)) dut (
    .clk_i  (clk),
    .rst_ni (rst_n),
    .bus    (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic rvalid, input logic [DW-1:0] data, input logic [1:0] resp,
                               input logic clr, input logic ld, input logic [PW-1:0] ptr, input logic req);
    bus.axi_rvalid      = rvalid;
    bus.axi_rdata       = data;
    bus.axi_rresp       = resp;
    bus.page_clr        = clr;
    bus.ld_rdfifo_rdptr = ld;
    bus.rdfifo_rdptr    = ptr;
    bus.rd_req          = req;
  endtask

  task automatic waitCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [DW-1:0] observed, input logic [DW-1:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("rst_rd_valid", DW'(bus.rd_valid), DW'(0));
    checkOutput("rst_rd_data", bus.rd_data, '0);
    checkOutput("rst_rd_rresp", DW'(bus.rd_rresp), DW'(0));
    checkOutput("rst_empty", DW'(bus.rdfifo_empty), DW'(1));
    checkOutput("rst_full", DW'(bus.page_full), DW'(0));
    checkOutput("rst_rready", DW'(bus.axi_rready), DW'(1));
`ifdef HACD_RDFIFO_ZERO_CNT_EN
    checkOutput("rst_zero_cnt", DW'(bus.zero_line_cnt), DW'(0));
`endif
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    waitCycle();

    $display("[TB] full page write, data = index");
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, DW'(i), 2'b00, 1'b0, 1'b0, '0, 1'b0);
      waitCycle();
      if (i == 0) checkOutput("first_beat_not_empty", DW'(bus.rdfifo_empty), DW'(0));
      if (i == 62) checkOutput("not_full_at_63", DW'(bus.page_full), DW'(0));
    end
    applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("full_after_64", DW'(bus.page_full), DW'(1));
    checkOutput("rready_low_full", DW'(bus.axi_rready), DW'(0));

    $display("[TB] 64 back-to-back reads");
    applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b0, '0, 1'b1);
    for (int i = 0; i < 64; i++) begin
      waitCycle();
      checkOutput($sformatf("b2b_valid_%0d", i), DW'(bus.rd_valid), DW'(1));
      checkOutput($sformatf("b2b_data_%0d", i), bus.rd_data, DW'(i));
    end
    applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("empty_after_64_reads", DW'(bus.rdfifo_empty), DW'(1));
    waitCycle();
    checkOutput("valid_drops", DW'(bus.rd_valid), DW'(0));

    $display("[TB] pointer load to 47 with same-cycle read");
    applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b1, PW'(47), 1'b1);
    waitCycle();
    checkOutput("ld_valid", DW'(bus.rd_valid), DW'(1));
    checkOutput("ld_data_47", bus.rd_data, DW'(47));
    applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b0, '0, 1'b1);
    for (int k = 48; k < 64; k++) begin
      waitCycle();
      checkOutput($sformatf("ld_data_%0d", k), bus.rd_data, DW'(k));
    end
    waitCycle();
    checkOutput("empty_req_ignored", DW'(bus.rd_valid), DW'(0));
    applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b1, PW'(0), 1'b0);
    waitCycle();
    checkOutput("ld_only_not_empty", DW'(bus.rdfifo_empty), DW'(0));

    $display("[TB] page_clr against write and read");
    applyStimulus(1'b1, DW'(85), 2'b00, 1'b1, 1'b0, '0, 1'b1);
    #1;
    checkOutput("clr_rready_low", DW'(bus.axi_rready), DW'(0));
    waitCycle();
    checkOutput("clr_no_valid", DW'(bus.rd_valid), DW'(0));
    checkOutput("clr_empty", DW'(bus.rdfifo_empty), DW'(1));
    checkOutput("clr_not_full", DW'(bus.page_full), DW'(0));
    applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b0, '0, 1'b0);
    #1;
    checkOutput("clr_rready_back", DW'(bus.axi_rready), DW'(1));

    $display("[TB] three beats with an error response");
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, DW'(100 + i), (i == 1) ? 2'b10 : 2'b00, 1'b0, 1'b0, '0, 1'b0);
      waitCycle();
    end
    applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b0, '0, 1'b1);
    waitCycle();
    checkOutput("resp_rd0", DW'(bus.rd_rresp), DW'(0));
    checkOutput("data_rd0", bus.rd_data, DW'(100));
    waitCycle();
    checkOutput("resp_rd1", DW'(bus.rd_rresp), DW'(2));
    checkOutput("data_rd1", bus.rd_data, DW'(101));
    waitCycle();
    checkOutput("resp_rd2", DW'(bus.rd_rresp), DW'(0));
    checkOutput("valid_rd2", DW'(bus.rd_valid), DW'(1));
    waitCycle();
    checkOutput("no_valid_rd3", DW'(bus.rd_valid), DW'(0));

    applyStimulus(1'b1, DW'(7), 2'b00, 1'b1, 1'b0, '0, 1'b0);
    #1;
    checkOutput("clr_rready_partial", DW'(bus.axi_rready), DW'(0));
    waitCycle();

    $display("[TB] write-to-read visibility with concurrent write");
    applyStimulus(1'b1, DW'(200), 2'b00, 1'b0, 1'b0, '0, 1'b0);
    waitCycle();
    applyStimulus(1'b1, DW'(201), 2'b01, 1'b0, 1'b0, '0, 1'b1);
    waitCycle();
    checkOutput("vis_valid", DW'(bus.rd_valid), DW'(1));
    checkOutput("vis_data_200", bus.rd_data, DW'(200));
    applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b0, '0, 1'b1);
    waitCycle();
    checkOutput("vis_data_201", bus.rd_data, DW'(201));
    checkOutput("vis_resp_201", DW'(bus.rd_rresp), DW'(1));

    $display("[TB] zero-line page");
    applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b0, '0, 1'b0);
    waitCycle();
    for (int i = 0; i < 64; i++) begin
      applyStimulus(1'b1, ((i >= 16 && i < 32) || i == 5) ? DW'(0) : DW'(i + 1),
                    (i == 5) ? 2'b01 : 2'b00, 1'b0, 1'b0, '0, 1'b0);
      waitCycle();
    end
    applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("zpage_full", DW'(bus.page_full), DW'(1));
`ifdef HACD_RDFIFO_ZERO_CNT_EN
    checkOutput("zero_cnt_16", DW'(bus.zero_line_cnt), DW'(16));
`endif

    $display("[TB] reset mid-page");
    applyStimulus(1'b0, '0, 2'b00, 1'b1, 1'b0, '0, 1'b0);
    waitCycle();
`ifdef HACD_RDFIFO_ZERO_CNT_EN
    checkOutput("zero_cnt_clr", DW'(bus.zero_line_cnt), DW'(0));
`endif
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, DW'(i), 2'b00, 1'b0, 1'b0, '0, 1'b0);
      waitCycle();
    end
    applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b0, '0, 1'b1);
    repeat (4) waitCycle();
    applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b0, '0, 1'b0);
    checkOutput("pre_rst_data_3", bus.rd_data, DW'(3));
`ifdef HACD_RDFIFO_ZERO_CNT_EN
    checkOutput("pre_rst_zero_cnt", DW'(bus.zero_line_cnt), DW'(1));
`endif
    #1;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_rd_valid", DW'(bus.rd_valid), DW'(0));
    checkOutput("arst_rd_data", bus.rd_data, '0);
    checkOutput("arst_rd_rresp", DW'(bus.rd_rresp), DW'(0));
    checkOutput("arst_empty", DW'(bus.rdfifo_empty), DW'(1));
    checkOutput("arst_full", DW'(bus.page_full), DW'(0));
    checkOutput("arst_rready", DW'(bus.axi_rready), DW'(1));
`ifdef HACD_RDFIFO_ZERO_CNT_EN
    checkOutput("arst_zero_cnt", DW'(bus.zero_line_cnt), DW'(0));
`endif
    waitCycle();
    rst_n = 1'b1;
    applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b0, '0, 1'b1);
    waitCycle();
    checkOutput("post_rst_no_read", DW'(bus.rd_valid), DW'(0));
    applyStimulus(1'b0, '0, 2'b00, 1'b0, 1'b0, '0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
